// File: rtl/mux_step_ctrl_if.sv
// Wishbone slave bus of the multiplexer step controller.
// slave = the controller itself, master = the bus side (caravel or a bench).
interface mux_step_ctrl_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/mux_step_ctrl.sv
// Wishbone sequencer for the design multiplexer: safe address switch, reset pulses, clock stepping.
// Optional step-done interrupt (irq_o, irq_pend flop) is built only with MUX_CTRL_IRQ_EN defined.
module mux_step_ctrl #(
  parameter int RST_HOLD = 4,
  parameter int STEP_DIV = 1,
  parameter int CNT_W    = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  mux_step_ctrl_if.slave  wb,
  output logic            override_o,
  output logic [3:0]      design_addr_o,
  output logic            design_rst_o,
  output logic            step_clk_o,
  output logic            busy_o
`ifdef MUX_CTRL_IRQ_EN
  ,
  output logic            irq_o
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_RST  = 3'd1,
    SWAP     = 3'd2,
    POST_RST = 3'd3,
    STEP_HI  = 3'd4,
    STEP_LO  = 3'd5
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STEP   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSTCMD = 2'd3;

  localparam int MAXP = (RST_HOLD > STEP_DIV) ? RST_HOLD : STEP_DIV;
  localparam int PW   = $clog2(MAXP + 1);
  localparam logic [PW-1:0] HOLD_LAST = PW'(RST_HOLD - 1);
  localparam logic [PW-1:0] DIV_LAST  = PW'(STEP_DIV - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       target_q, target_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             rst_q, step_q, busy_q;

  logic             access, wr, cmd_wr, idle, step_done;
  logic [1:0]       sel;
  logic [31:0]      wdat;
  logic             unused_bits;

  // Only a few address and data bits are decoded; the rest are ignored.
  assign unused_bits = ^{wb.wbs_adr_i, wb.wbs_dat_i};

  assign access = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
  assign wr     = access & wb.wbs_we_i;
  assign sel    = wb.wbs_adr_i[3:2];
  assign wdat   = wb.wbs_dat_i;
  assign cmd_wr = wr && (sel != REG_STATUS);
  assign idle   = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PW'(1);
    rem_d     = rem_q;
    addr_d    = addr_q;
    target_d  = target_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    step_done = 1'b0;

    // The override enable bit is honoured even while a sequence is running.
    if (wr && sel == REG_CTRL) ovr_d = wdat[0];
    if (cmd_wr && !idle) err_d = 1'b1;
    if (wr && sel == REG_STATUS && wdat[8]) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (wr) begin
          case (sel)
            REG_CTRL: begin
              target_d = wdat[7:4];
              if (wdat[7:4] != addr_q) state_d = PRE_RST;
            end
            REG_STEP: begin
              if (wdat[CNT_W-1:0] != '0) begin
                rem_d   = wdat[CNT_W-1:0];
                state_d = STEP_HI;
              end
            end
            REG_RSTCMD: if (wdat[0]) state_d = POST_RST;
            default: ;
          endcase
        end
      end
      PRE_RST: begin
        if (phase_q == HOLD_LAST) begin
          state_d = SWAP;
          phase_d = '0;
          addr_d  = target_q;
        end
      end
      SWAP: begin
        state_d = POST_RST;
        phase_d = '0;
      end
      POST_RST: begin
        if (phase_q == HOLD_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      STEP_HI: begin
        state_d = STEP_LO;
        phase_d = '0;
        if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
      end
      STEP_LO: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          if (rem_q == '0) begin
            state_d   = IDLE;
            step_done = 1'b1;
          end else begin
            state_d = STEP_HI;
          end
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

`ifdef MUX_CTRL_IRQ_EN
  always_comb begin
    irq_d = irq_q;
    if (wr && sel == REG_STATUS && wdat[9]) irq_d = 1'b0;
    if (step_done) irq_d = 1'b1;
  end
  assign irq_o = irq_q;
`else
  assign irq_d = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (sel)
      REG_CTRL:   rdata_d = {24'd0, target_q, 3'd0, ovr_q};
      REG_STEP:   rdata_d = 32'(rem_q);
      REG_STATUS: rdata_d = {22'd0, irq_q, err_q, addr_q, state_q, busy_q};
      default:    rdata_d = '0;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      target_q <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      rst_q    <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      ack_q    <= access;
      rdata_q  <= access ? rdata_d : '0;
      rst_q    <= (state_d == PRE_RST) || (state_d == SWAP) || (state_d == POST_RST);
      step_q   <= (state_d == STEP_HI);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign wb.wbs_ack_o  = ack_q;
  assign wb.wbs_dat_o  = rdata_q;
  assign override_o    = ovr_q;
  assign design_addr_o = addr_q;
  assign design_rst_o  = rst_q;
  assign step_clk_o    = step_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mux_step_ctrl.sv
// Directed bench for mux_step_ctrl (RST_HOLD=4, STEP_DIV=1, CNT_W=16).
module tb_mux_step_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       override_o, design_rst_o, step_clk_o, busy_o;
  logic [3:0] design_addr_o;
`ifdef MUX_CTRL_IRQ_EN
  logic       irq_o;
`endif
  int checks = 0;
  int errors = 0;

  mux_step_ctrl_if wb();

  mux_step_ctrl #(.RST_HOLD(4), .STEP_DIV(1), .CNT_W(16)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb            (wb),
    .override_o    (override_o),
    .design_addr_o (design_addr_o),
    .design_rst_o  (design_rst_o),
    .step_clk_o    (step_clk_o),
    .busy_o        (busy_o)
`ifdef MUX_CTRL_IRQ_EN
    ,
    .irq_o         (irq_o)
`endif
  );

  always #5 clk = ~clk;

  // Returns #1 after the edge that raised ack; writes are visible at that point.
  task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                     output logic [31:0] rdat);
    bit got;
    got  = 0;
    rdat = '0;
    @(negedge clk);
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_we_i  = we;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o === 1'b1) begin
        got  = 1;
        rdat = wb.wbs_dat_o;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_ack adr=%h: no ack within 8 cycles", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    bus(adr, dat, 1'b1, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    bus(adr, 32'd0, 1'b0, dat);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({override_o, design_addr_o, design_rst_o, step_clk_o, busy_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {override_o, design_addr_o, design_rst_o, step_clk_o, busy_o});
    end
`ifdef MUX_CTRL_IRQ_EN
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq_o); end
`endif
    rst = 1'b0;
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 0", r); end
  endtask

  task automatic test_noop_ctrl();
    logic [31:0] r;
    wb_write(32'h0, 32'h01);
    repeat (2) begin
      checks++;
      if ({busy_o, design_rst_o, override_o} !== 3'b001) begin
        errors++;
        $display("FAIL noop_ctrl: busy/rst/ovr=%b, required 001", {busy_o, design_rst_o, override_o});
      end
      @(posedge clk); #1;
    end
    wb_read(32'h0, r);
    checks++;
    if (r !== 32'h01) begin errors++; $display("FAIL noop_ctrl_read: got %h, required 01", r); end
  endtask

  task automatic test_switch();
    int n, bad_busy;
    logic [3:0] a4, a5;
    wb_write(32'h0, 32'h31);
    checks++;
    if (override_o !== 1'b1) begin errors++; $display("FAIL switch_ovr: got %b, required 1", override_o); end
    n = 0; bad_busy = 0; a4 = 'x; a5 = 'x;
    while (design_rst_o === 1'b1 && n < 40) begin
      n++;
      if (busy_o !== 1'b1) bad_busy++;
      if (n == 4) a4 = design_addr_o;
      if (n == 5) a5 = design_addr_o;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 9) begin errors++; $display("FAIL switch_rst_len: got %0d, required 9", n); end
    checks++;
    if (a4 !== 4'd0) begin errors++; $display("FAIL switch_addr4: got %h, required 0", a4); end
    checks++;
    if (a5 !== 4'd3) begin errors++; $display("FAIL switch_addr5: got %h, required 3", a5); end
    checks++;
    if (bad_busy != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL switch_busy: bad=%0d busy_after=%b, required 0/0", bad_busy, busy_o);
    end
    checks++;
    if (design_addr_o !== 4'd3) begin errors++; $display("FAIL switch_addr_final: got %h, required 3", design_addr_o); end
  endtask

  task automatic test_step();
    logic [5:0] pat;
    logic [1:0] pat1;
    logic [31:0] r;
    wb_write(32'h4, 32'd3);
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = step_clk_o;
      @(posedge clk); #1;
    end
    checks++;
    if (pat !== 6'b101010) begin errors++; $display("FAIL step3_pattern: got %b, required 101010", pat); end
    checks++;
    if ({busy_o, step_clk_o} !== 2'b00) begin
      errors++; $display("FAIL step3_done: busy/clk=%b, required 00", {busy_o, step_clk_o});
    end
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL step3_remaining: got %0d, required 0", r); end

    wb_write(32'h4, 32'd1);
    for (int i = 0; i < 2; i++) begin
      pat1[1-i] = step_clk_o;
      @(posedge clk); #1;
    end
    checks++;
    if (pat1 !== 2'b10 || busy_o !== 1'b0) begin
      errors++; $display("FAIL step1_pattern: got %b busy=%b, required 10 busy=0", pat1, busy_o);
    end
`ifdef MUX_CTRL_IRQ_EN
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL step_irq: got %b, required 1", irq_o); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h230) begin errors++; $display("FAIL step_status_irq: got %h, required 230", r); end
    wb_write(32'h8, 32'h200);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq_o); end
`else
    wb_write(32'h8, 32'h200);
`endif
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h030) begin errors++; $display("FAIL step_status: got %h, required 030", r); end
  endtask

  task automatic test_busy_drop();
    int pulses;
    logic [31:0] r;
    wb_write(32'h0, 32'h51);
    wb_write(32'h4, 32'd5);
    wb_write(32'h0, 32'h90);
    checks++;
    if (override_o !== 1'b0) begin errors++; $display("FAIL busy_ovr_update: got %b, required 0", override_o); end
    pulses = 0;
    for (int i = 0; i < 40 && busy_o === 1'b1; i++) begin
      if (step_clk_o === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    repeat (3) begin
      if (step_clk_o === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL busy_drop_pulses: pulses=%0d busy=%b, required 0/0", pulses, busy_o);
    end
    checks++;
    if (design_addr_o !== 4'd5) begin errors++; $display("FAIL busy_drop_addr: got %h, required 5", design_addr_o); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h150) begin errors++; $display("FAIL busy_err_set: got %h, required 150", r); end
    wb_write(32'h8, 32'h100);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h050) begin errors++; $display("FAIL busy_err_clear: got %h, required 050", r); end
    wb_read(32'h0, r);
    checks++;
    if (r !== 32'h050) begin errors++; $display("FAIL busy_ctrl_read: got %h, required 050", r); end
  endtask

  task automatic test_rstcmd();
    int n, bad_addr;
    logic [31:0] r;
    wb_write(32'h0, 32'h71);
    wait_idle();
    checks++;
    if (design_addr_o !== 4'd7) begin errors++; $display("FAIL rstcmd_setup_addr: got %h, required 7", design_addr_o); end
    wb_write(32'hC, 32'h1);
    n = 0; bad_addr = 0;
    while (design_rst_o === 1'b1 && n < 40) begin
      n++;
      if (design_addr_o !== 4'd7) bad_addr++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rstcmd_len: got %0d, required 4", n); end
    checks++;
    if (bad_addr != 0 || design_addr_o !== 4'd7) begin
      errors++; $display("FAIL rstcmd_addr: bad=%0d addr=%h, required 0/7", bad_addr, design_addr_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rstcmd_busy: got %b, required 0", busy_o); end
    wb_read(32'hC, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rstcmd_read: got %h, required 0", r); end
  endtask

  task automatic test_reset_mid_step();
    int p;
    logic [31:0] r;
    wb_write(32'h4, 32'd100);
    p = 0;
    for (int i = 0; i < 60 && p < 10; i++) begin
      if (step_clk_o === 1'b1) p++;
      if (p < 10) begin @(posedge clk); #1; end
    end
    checks++;
    if (p != 10) begin errors++; $display("FAIL midstep_pulses: got %0d, required 10", p); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({override_o, design_addr_o, design_rst_o, step_clk_o, busy_o} !== 8'h00) begin
      errors++;
      $display("FAIL midstep_outputs: got %b, required 00000000",
               {override_o, design_addr_o, design_rst_o, step_clk_o, busy_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL midstep_remaining: got %0d, required 0", r); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midstep_status: got %h, required 0", r); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (step_clk_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL midstep_quiet: clk=%b busy=%b, required 0/0", step_clk_o, busy_o);
    end
`ifdef MUX_CTRL_IRQ_EN
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL midstep_irq: got %b, required 0", irq_o); end
`endif
  endtask

  initial begin
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    test_reset();
    test_noop_ctrl();
    test_switch();
    test_step();
    test_busy_drop();
    test_rstcmd();
    test_reset_mid_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
